jtag_tap_param: RTL and testbench

JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

---
 rtl/jtag_tap_param_if.sv | 26 ++
 rtl/jtag_tap_param.sv | 143 ++++++++++++++
 tb/tb_jtag_tap_param.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_param_if.sv
// Serial scan and user-register signals of the parameterised JTAG TAP.
// TCK and TRST stay plain ports on the TAP itself.
interface jtag_tap_param_if #(
  parameter int IR_WIDTH = 4,
  parameter int DR_WIDTH = 16
);
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_EN;
  logic [3:0]          state;
  logic [IR_WIDTH-1:0] ir;
  logic [DR_WIDTH-1:0] dr_in;
  logic [DR_WIDTH-1:0] dr_out;
  logic                update_pulse;

  modport master (
    output TMS, TDI, dr_in,
    input  TDO, TDO_EN, state, ir, dr_out, update_pulse
  );

  modport slave (
    input  TMS, TDI, dr_in,
    output TDO, TDO_EN, state, ir, dr_out, update_pulse
  );
endinterface

// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 TAP controller with IDCODE, user DR and bypass registers.
// All state moves on rising TCK; TDO/TDO_EN are retimed to falling TCK.
module jtag_tap_param #(
  parameter int                  IR_WIDTH   = 4,
  parameter int                  DR_WIDTH   = 16,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(7),
  parameter logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(5),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS  = '1
) (
  input  logic             TCK,
  input  logic             TRST,
  jtag_tap_param_if.slave  bus
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]         ID_CAPTURE = {IDCODE_VAL[31:1], 1'b1};

  tap_state_e          state_q;
  logic [IR_WIDTH-1:0] ir_q;
  logic [IR_WIDTH-1:0] ir_sr_q;
  logic [31:0]         id_sr_q;
  logic [DR_WIDTH-1:0] user_sr_q;
  logic                byp_sr_q;
  logic [DR_WIDTH-1:0] dr_out_q;
  logic                upd_q;
  logic                tdo_q;
  logic                tdo_en_q;

  logic [IR_WIDTH-1:0] ir_shift_d;
  logic [DR_WIDTH-1:0] user_shift_d;
  logic                sel_id;
  logic                sel_user;
  logic                sel_byp;
  logic                dr_lsb;

  assign sel_id   = (ir_q == OP_IDCODE);
  assign sel_user = !sel_id && (ir_q == OP_USER);
  assign sel_byp  = (ir_q == OP_BYPASS) || !(sel_id || sel_user);
  assign dr_lsb   = sel_id ? id_sr_q[0] : (sel_user ? user_sr_q[0] : byp_sr_q);

  assign ir_shift_d = {bus.TDI, ir_sr_q[IR_WIDTH-1:1]};

  // A one-bit user register has no upper bits to shift down.
  generate
    if (DR_WIDTH == 1) begin : g_user_one
      assign user_shift_d = bus.TDI;
    end else begin : g_user_wide
      assign user_shift_d = {bus.TDI, user_sr_q[DR_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      state_q   <= TLR;
      ir_q      <= OP_IDCODE;
      ir_sr_q   <= '0;
      id_sr_q   <= '0;
      user_sr_q <= '0;
      byp_sr_q  <= 1'b0;
      dr_out_q  <= '0;
      upd_q     <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        TLR: begin
          ir_q    <= OP_IDCODE;
          state_q <= bus.TMS ? TLR : RTI;
        end
        RTI:    state_q <= bus.TMS ? SEL_DR : RTI;
        SEL_DR: state_q <= bus.TMS ? SEL_IR : CAP_DR;
        CAP_DR: begin
          if (sel_id)   id_sr_q   <= ID_CAPTURE;
          if (sel_user) user_sr_q <= bus.dr_in;
          if (sel_byp)  byp_sr_q  <= 1'b0;
          state_q <= bus.TMS ? EX1_DR : SH_DR;
        end
        SH_DR: begin
          if (sel_id)   id_sr_q   <= {bus.TDI, id_sr_q[31:1]};
          if (sel_user) user_sr_q <= user_shift_d;
          if (sel_byp)  byp_sr_q  <= bus.TDI;
          state_q <= bus.TMS ? EX1_DR : SH_DR;
        end
        EX1_DR: state_q <= bus.TMS ? UPD_DR : PAU_DR;
        PAU_DR: state_q <= bus.TMS ? EX2_DR : PAU_DR;
        EX2_DR: state_q <= bus.TMS ? UPD_DR : SH_DR;
        UPD_DR: begin
          if (sel_user) begin
            dr_out_q <= user_sr_q;
            upd_q    <= 1'b1;
          end
          state_q <= bus.TMS ? SEL_DR : RTI;
        end
        SEL_IR: state_q <= bus.TMS ? TLR : CAP_IR;
        CAP_IR: begin
          ir_sr_q <= IR_CAPTURE;
          state_q <= bus.TMS ? EX1_IR : SH_IR;
        end
        SH_IR: begin
          ir_sr_q <= ir_shift_d;
          state_q <= bus.TMS ? EX1_IR : SH_IR;
        end
        EX1_IR: state_q <= bus.TMS ? UPD_IR : PAU_IR;
        PAU_IR: state_q <= bus.TMS ? EX2_IR : PAU_IR;
        EX2_IR: state_q <= bus.TMS ? UPD_IR : SH_IR;
        UPD_IR: begin
          ir_q    <= ir_sr_q;
          state_q <= bus.TMS ? SEL_DR : RTI;
        end
        default: state_q <= TLR;
      endcase
    end
  end

  // Falling-edge retiming gives the external capture a half-cycle of setup.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_en_q <= (state_q == SH_IR) || (state_q == SH_DR);
      if (state_q == SH_IR)      tdo_q <= ir_sr_q[0];
      else if (state_q == SH_DR) tdo_q <= dr_lsb;
      else                       tdo_q <= 1'b0;
    end
  end

  assign bus.TDO          = tdo_q;
  assign bus.TDO_EN       = tdo_en_q;
  assign bus.state        = state_q;
  assign bus.ir           = ir_q;
  assign bus.dr_out       = dr_out_q;
  assign bus.update_pulse = upd_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed scan scenarios for jtag_tap_param with hand-computed expectations.
module tb_jtag_tap_param;
  logic TCK;
  logic TRST;
  int   total;
  int   bad;
  logic [63:0] dout;
  logic        upd_seen;

  jtag_tap_param_if #(.IR_WIDTH(4), .DR_WIDTH(16)) bus ();

  jtag_tap_param #(
    .IR_WIDTH(4), .DR_WIDTH(16), .IDCODE_VAL(32'h1000_0001),
    .OP_IDCODE(4'h7), .OP_USER(4'h5), .OP_BYPASS(4'hF)
  ) dut (
    .TCK (TCK),
    .TRST(TRST),
    .bus (bus)
  );

  initial TCK = 1'b0;
  always #5 TCK = ~TCK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are read there too.
  task automatic step(input logic tms, input logic tdi);
    bus.TMS = tms;
    bus.TDI = tdi;
    @(negedge TCK);
    #1;
  endtask

  task automatic shift(input int n, input logic [63:0] din, output logic [63:0] out);
    out = '0;
    for (int i = 0; i < n; i++) begin
      out[i] = bus.TDO;
      step(i == n - 1, din[i]);
    end
  endtask

  task automatic ir_scan(input int n, input logic [63:0] din, output logic [63:0] out);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    shift(n, din, out);
    step(1, 0); step(0, 0);
    $display("ir scan n=%0d in=%h out=%h ir=%h", n, din, out, bus.ir);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] out,
                         output logic upd);
    step(1, 0); step(0, 0); step(0, 0);
    shift(n, din, out);
    step(1, 0); step(0, 0);
    upd = bus.update_pulse;
    $display("dr scan n=%0d in=%h out=%h dr_out=%h upd=%b", n, din, out, bus.dr_out, upd);
  endtask

  initial begin
    logic [63:0] part;
    total = 0;
    bad   = 0;
    TRST      = 1'b1;
    bus.TMS   = 1'b1;
    bus.TDI   = 1'b0;
    bus.dr_in = 16'h1234;
    #12;
    chk("rst_state", bus.state, 4'hF);
    chk("rst_ir", bus.ir, 4'h7);
    chk("rst_dr_out", bus.dr_out, 16'h0);
    chk("rst_tdo", bus.TDO, 1'b0);
    chk("rst_tdo_en", bus.TDO_EN, 1'b0);
    chk("rst_upd", bus.update_pulse, 1'b0);
    TRST = 1'b0;
    step(0, 0);
    chk("rti_state", bus.state, 4'hC);
    $display("reset released state=%h", bus.state);

    // IDCODE out of reset
    dr_scan(32, 64'h0, dout, upd_seen);
    chk("idcode_out", dout[31:0], 32'h1000_0001);
    chk("idcode_no_upd", upd_seen, 1'b0);
    chk("idcode_dr_out", bus.dr_out, 16'h0);

    // IR <- 5
    ir_scan(4, 64'h5, dout);
    chk("ir5_tdo", dout[3:0], 4'b0001);
    chk("ir5_ir", bus.ir, 4'h5);

    // User DR with a 4-cycle pause in the middle
    step(1, 0); step(0, 0); step(0, 0);
    chk("user_tdo_en", bus.TDO_EN, 1'b1);
    shift(8, 64'hAA, dout);
    step(0, 0);
    for (int i = 0; i < 3; i++) step(0, 0);
    chk("pause_state", bus.state, 4'h3);
    chk("pause_tdo_en", bus.TDO_EN, 1'b0);
    step(1, 0); step(0, 0);
    shift(8, 64'hAA, part);
    dout[15:8] = part[7:0];
    step(1, 0); step(0, 0);
    $display("user scan out=%h dr_out=%h upd=%b", dout[15:0], bus.dr_out, bus.update_pulse);
    chk("user_out", dout[15:0], 16'h1234);
    chk("user_dr_out", bus.dr_out, 16'hAAAA);
    chk("user_upd_hi", bus.update_pulse, 1'b1);
    step(0, 0);
    chk("user_upd_lo", bus.update_pulse, 1'b0);

    // Over-length IR scan keeps the last four bits
    ir_scan(6, 64'h35, dout);
    chk("ir_long_tdo", dout[5:0], 6'b010001);
    chk("ir_long_ir", bus.ir, 4'hD);

    // Bypass
    ir_scan(4, 64'hF, dout);
    chk("irF_ir", bus.ir, 4'hF);
    dr_scan(8, 64'h81, dout, upd_seen);
    chk("byp_out", dout[7:0], 8'h02);
    chk("byp_no_upd", upd_seen, 1'b0);
    chk("byp_dr_out", bus.dr_out, 16'hAAAA);

    // TMS-driven reset from ShIR
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("shir_state", bus.state, 4'hA);
    chk("shir_tdo_en", bus.TDO_EN, 1'b1);
    for (int i = 0; i < 5; i++) step(1, 0);
    $display("tms reset state=%h ir=%h", bus.state, bus.ir);
    chk("tms_rst_state", bus.state, 4'hF);
    step(1, 0);
    chk("tms_rst_ir", bus.ir, 4'h7);
    chk("tms_rst_dr_out", bus.dr_out, 16'hAAAA);
    chk("tms_rst_upd", bus.update_pulse, 1'b0);
    step(0, 0);

    // TRST pulse in the middle of a user DR shift
    ir_scan(4, 64'h5, dout);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 3; i++) step(0, 1);
    chk("mid_shdr_state", bus.state, 4'h2);
    #1 TRST = 1'b1;
    #1;
    $display("trst mid-shift state=%h ir=%h dr_out=%h", bus.state, bus.ir, bus.dr_out);
    chk("trst_state", bus.state, 4'hF);
    chk("trst_ir", bus.ir, 4'h7);
    chk("trst_dr_out", bus.dr_out, 16'h0);
    chk("trst_tdo_en", bus.TDO_EN, 1'b0);
    chk("trst_tdo", bus.TDO, 1'b0);
    chk("trst_upd", bus.update_pulse, 1'b0);
    #1 TRST = 1'b0;
    step(0, 0);
    chk("resume_state", bus.state, 4'hC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
